// File: rtl/proc_pkg.sv
// Shared pipeline-control definitions.
//   FWD_*      : ex_fwd_sel encoding (per source, 2 bits; 3 is reserved)
//   hz_state_e : hazard controller state (RUN, SQUASH, MEMWAIT)
package proc_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;  // register file / ID value
  localparam logic [1:0] FWD_MEM = 2'd1;  // EX/MEM alu_out
  localparam logic [1:0] FWD_WB  = 2'd2;  // MEM/WB wb_data

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SQUASH  = 2'd1,
    MEMWAIT = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_match.sv
// Per-source dependency comparator for one ID source operand.
//   id_valid_i, src_used_i : operand is real and actually read
//   src_i                  : source register index
//   {ex,mem,wb}_wen_i/rd_i : producer write enable / destination per stage
//   {ex,mem,wb}_hit_o      : operand depends on that stage's result
// Register 0 is compared like any other register.
module hazard_match #(
  parameter int REG_BITS = 3
) (
  input  logic                id_valid_i,
  input  logic                src_used_i,
  input  logic [REG_BITS-1:0] src_i,
  input  logic                ex_wen_i,
  input  logic [REG_BITS-1:0] ex_rd_i,
  input  logic                mem_wen_i,
  input  logic [REG_BITS-1:0] mem_rd_i,
  input  logic                wb_wen_i,
  input  logic [REG_BITS-1:0] wb_rd_i,
  output logic                ex_hit_o,
  output logic                mem_hit_o,
  output logic                wb_hit_o
);

  logic rd_en;
  assign rd_en     = id_valid_i & src_used_i;
  assign ex_hit_o  = rd_en & ex_wen_i  & (src_i == ex_rd_i);
  assign mem_hit_o = rd_en & mem_wen_i & (src_i == mem_rd_i);
  assign wb_hit_o  = rd_en & wb_wen_i  & (src_i == wb_rd_i);

endmodule

// File: rtl/hazard_ctl.sv
// Hazard and forwarding controller for the IF/ID/EX/MEM/WB pipeline.
// Handles load-use stalls, EX-resolved mispredict squashes and data-memory
// waits, and produces registered forwarding selects for the EX instruction.
//   clk, rst        : clock, async active-low reset
//   id_*            : ID instruction sources (src k = id_src[k*REG_BITS +: REG_BITS])
//   ex_/mem_/wb_*   : producer write enables / destinations
//   ex_mispredict   : branch in EX mispredicted
//   dmem_busy       : data memory not completing this cycle
//   stall_front, bubble_idex, flush_front, stall_all, bubble_wb : boundary controls
//   id_wb_bypass    : per-source WB bypass into decode (combinational)
//   ex_fwd_sel      : per-source forwarding select, registered with ID/EX
// Optional macro HAZARD_PERF_EN adds perf_clr and three saturating counters
// (perf_lu_stalls, perf_squash, perf_memwait) of PERF_W bits.
module hazard_ctl
  import proc_pkg::*;
#(
  parameter int REG_BITS     = 3,
  parameter int N_SRC        = 2,
  parameter int SQUASH_DEPTH = 2,
  parameter int PERF_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [N_SRC*REG_BITS-1:0] id_src,
  input  logic [N_SRC-1:0]          id_src_used,
  input  logic                      ex_wen,
  input  logic                      ex_is_load,
  input  logic [REG_BITS-1:0]       ex_rd,
  input  logic                      mem_wen,
  input  logic [REG_BITS-1:0]       mem_rd,
  input  logic                      wb_wen,
  input  logic [REG_BITS-1:0]       wb_rd,
  input  logic                      ex_mispredict,
  input  logic                      dmem_busy,
  output logic                      stall_front,
  output logic                      bubble_idex,
  output logic                      flush_front,
  output logic                      stall_all,
  output logic                      bubble_wb,
  output logic [N_SRC-1:0]          id_wb_bypass,
  output logic [2*N_SRC-1:0]        ex_fwd_sel
`ifdef HAZARD_PERF_EN
  ,
  input  logic                      perf_clr,
  output logic [PERF_W-1:0]         perf_lu_stalls,
  output logic [PERF_W-1:0]         perf_squash,
  output logic [PERF_W-1:0]         perf_memwait
`endif
);

  localparam int CW = $clog2(SQUASH_DEPTH + 1);

  if (SQUASH_DEPTH < 2 || PERF_W < 1) begin : g_cfg_err
    $error("hazard_ctl: SQUASH_DEPTH must be >= 2 and PERF_W >= 1");
  end

  logic [N_SRC-1:0]   ex_hit, mem_hit;
  logic [2*N_SRC-1:0] fwd_id;

  for (genvar k = 0; k < N_SRC; k++) begin : g_src
    hazard_match #(.REG_BITS(REG_BITS)) u_match (
      .id_valid_i (id_valid),
      .src_used_i (id_src_used[k]),
      .src_i      (id_src[k*REG_BITS +: REG_BITS]),
      .ex_wen_i   (ex_wen),
      .ex_rd_i    (ex_rd),
      .mem_wen_i  (mem_wen),
      .mem_rd_i   (mem_rd),
      .wb_wen_i   (wb_wen),
      .wb_rd_i    (wb_rd),
      .ex_hit_o   (ex_hit[k]),
      .mem_hit_o  (mem_hit[k]),
      .wb_hit_o   (id_wb_bypass[k])
    );
    // A load in EX has no alu_out worth forwarding; fall through to MEM.
    assign fwd_id[2*k +: 2] = (ex_hit[k] & ~ex_is_load) ? FWD_MEM :
                              mem_hit[k]                ? FWD_WB  : FWD_RF;
  end

  logic lu_hit;
  assign lu_hit = ex_is_load & (|ex_hit);

  hz_state_e state_q, state_d, saved_q, saved_d, run_st;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    cnt_d       = cnt_q;
    stall_front = 1'b0;
    bubble_idex = 1'b0;
    flush_front = 1'b0;
    stall_all   = 1'b0;
    bubble_wb   = 1'b0;
    // Leaving MEMWAIT resumes the saved state within the same cycle.
    run_st      = (state_q == MEMWAIT) ? saved_q : state_q;
    if (dmem_busy) begin
      stall_all = 1'b1;
      bubble_wb = 1'b1;
      state_d   = MEMWAIT;
      saved_d   = run_st;
    end else begin
      state_d = run_st;
      case (run_st)
        SQUASH: begin
          // EX holds a flushed slot here, so ex_mispredict is meaningless.
          flush_front = 1'b1;
          cnt_d       = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = RUN;
        end
        default: begin
          if (ex_mispredict) begin
            flush_front = 1'b1;
            if (SQUASH_DEPTH > 2) begin
              state_d = SQUASH;
              cnt_d   = CW'(SQUASH_DEPTH - 2);
            end
          end else if (lu_hit) begin
            stall_front = 1'b1;
            bubble_idex = 1'b1;
          end
        end
      endcase
    end
  end

  logic [2*N_SRC-1:0] fwd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      saved_q <= RUN;
      cnt_q   <= '0;
      fwd_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
      if (!stall_all) fwd_q <= (bubble_idex | flush_front) ? '0 : fwd_id;
    end
  end

  assign ex_fwd_sel = fwd_q;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] lu_q, sq_q, mw_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lu_q <= '0;
      sq_q <= '0;
      mw_q <= '0;
    end else if (perf_clr) begin
      lu_q <= '0;
      sq_q <= '0;
      mw_q <= '0;
    end else begin
      if (bubble_idex && !(&lu_q)) lu_q <= lu_q + 1'b1;
      if (flush_front && !(&sq_q)) sq_q <= sq_q + 1'b1;
      if (stall_all   && !(&mw_q)) mw_q <= mw_q + 1'b1;
    end
  end

  assign perf_lu_stalls = lu_q;
  assign perf_squash    = sq_q;
  assign perf_memwait   = mw_q;
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Bench for hazard_ctl: directed scenarios plus a randomized run checked
// against a cycle-level reference model. dut_a uses SQUASH_DEPTH=4,
// dut_b the default depth 2; both see the same inputs.
module tb_hazard_ctl;
  localparam int RB = 3;
  localparam int NS = 2;
  localparam int PW = 4;
  localparam int DA = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid, ex_wen, ex_is_load, mem_wen, wb_wen, ex_mispredict, dmem_busy;
  logic [NS*RB-1:0] id_src;
  logic [NS-1:0] id_src_used;
  logic [RB-1:0] ex_rd, mem_rd, wb_rd;

  logic sf_a, bi_a, fl_a, sa_a, bw_a, sf_b, bi_b, fl_b, sa_b, bw_b;
  logic [NS-1:0] byp_a, byp_b;
  logic [2*NS-1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_EN
  logic perf_clr;
  logic [PW-1:0] plu_a, psq_a, pmw_a, plu_b, psq_b, pmw_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctl #(.REG_BITS(RB), .N_SRC(NS), .SQUASH_DEPTH(DA), .PERF_W(PW)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .mem_wen(mem_wen),
    .mem_rd(mem_rd), .wb_wen(wb_wen), .wb_rd(wb_rd), .ex_mispredict(ex_mispredict),
    .dmem_busy(dmem_busy), .stall_front(sf_a), .bubble_idex(bi_a), .flush_front(fl_a),
    .stall_all(sa_a), .bubble_wb(bw_a), .id_wb_bypass(byp_a), .ex_fwd_sel(fwd_a)
`ifdef HAZARD_PERF_EN
    , .perf_clr(perf_clr), .perf_lu_stalls(plu_a), .perf_squash(psq_a), .perf_memwait(pmw_a)
`endif
  );

  hazard_ctl #(.REG_BITS(RB), .N_SRC(NS), .SQUASH_DEPTH(2), .PERF_W(PW)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .mem_wen(mem_wen),
    .mem_rd(mem_rd), .wb_wen(wb_wen), .wb_rd(wb_rd), .ex_mispredict(ex_mispredict),
    .dmem_busy(dmem_busy), .stall_front(sf_b), .bubble_idex(bi_b), .flush_front(fl_b),
    .stall_all(sa_b), .bubble_wb(bw_b), .id_wb_bypass(byp_b), .ex_fwd_sel(fwd_b)
`ifdef HAZARD_PERF_EN
    , .perf_clr(perf_clr), .perf_lu_stalls(plu_b), .perf_squash(psq_b), .perf_memwait(pmw_b)
`endif
  );

  task automatic set_idle();
    id_valid = 0; id_src = '0; id_src_used = '0;
    ex_wen = 0; ex_is_load = 0; ex_rd = '0;
    mem_wen = 0; mem_rd = '0; wb_wen = 0; wb_rd = '0;
    ex_mispredict = 0; dmem_busy = 0;
`ifdef HAZARD_PERF_EN
    perf_clr = 0;
`endif
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_idle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_idle();
    #1;
    checks++;
    if ({sf_a, bi_a, fl_a, sa_a, bw_a, byp_a, fwd_a} !== '0) begin
      errors++;
      $display("FAIL reset_outs got %b exp 0", {sf_a, bi_a, fl_a, sa_a, bw_a, byp_a, fwd_a});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({sf_a, bi_a, fl_a, sa_a, bw_a, fwd_a} !== '0) begin
      errors++;
      $display("FAIL reset_idle got %b exp 0", {sf_a, bi_a, fl_a, sa_a, bw_a, fwd_a});
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    id_valid = 1; id_src = {3'd5, 3'd3}; id_src_used = 2'b01;
    ex_wen = 1; ex_is_load = 1; ex_rd = 3'd3;
    #1;
    checks++;
    if ({sf_a, bi_a, fl_a, sa_a} !== 4'b1100) begin
      errors++;
      $display("FAIL lu_stall got %b exp 1100", {sf_a, bi_a, fl_a, sa_a});
    end
    @(negedge clk);  // condition still present: stall repeats
    #1;
    checks++;
    if ({sf_a, bi_a, fwd_a} !== 6'b110000) begin
      errors++;
      $display("FAIL lu_repeat got %b exp 110000", {sf_a, bi_a, fwd_a});
    end
    @(negedge clk);  // load moved to MEM, EX now a bubble
    ex_wen = 0; ex_is_load = 0; mem_wen = 1; mem_rd = 3'd3;
    #1;
    checks++;
    if ({sf_a, bi_a} !== 2'b00) begin
      errors++;
      $display("FAIL lu_release got %b exp 00", {sf_a, bi_a});
    end
    @(posedge clk);
    #1;
    checks++;
    if (fwd_a[1:0] !== 2'd2) begin
      errors++;
      $display("FAIL lu_fwd got %0d exp 2", fwd_a[1:0]);
    end
    @(negedge clk);  // load hits only an unused source
    set_idle();
    id_valid = 1; id_src = {3'd5, 3'd3}; id_src_used = 2'b10;
    ex_wen = 1; ex_is_load = 1; ex_rd = 3'd3;
    #1;
    checks++;
    if (sf_a !== 1'b0) begin
      errors++;
      $display("FAIL lu_unused got %b exp 0", sf_a);
    end
    drain(2);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    id_valid = 1; id_src = {3'd2, 3'd7}; id_src_used = 2'b10;
    ex_wen = 1; ex_rd = 3'd2; mem_wen = 1; mem_rd = 3'd2;
    @(posedge clk);
    #1;
    checks++;
    if (fwd_a !== 4'b0100) begin
      errors++;
      $display("FAIL b2b_ex got %b exp 0100", fwd_a);
    end
    @(negedge clk);
    ex_wen = 0;
    @(posedge clk);
    #1;
    checks++;
    if (fwd_a !== 4'b1000) begin
      errors++;
      $display("FAIL b2b_mem got %b exp 1000", fwd_a);
    end
    @(negedge clk);
    mem_wen = 0; wb_wen = 1; wb_rd = 3'd2;
    #1;
    checks++;
    if (byp_a !== 2'b10) begin
      errors++;
      $display("FAIL b2b_wb_bypass got %b exp 10", byp_a);
    end
    @(posedge clk);
    #1;
    checks++;
    if (fwd_a !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_wb_fwd got %b exp 0000", fwd_a);
    end
    @(negedge clk);  // r0 is an ordinary register
    id_src = {3'd0, 3'd0}; id_src_used = 2'b11; wb_wen = 0; ex_wen = 1; ex_rd = 3'd0;
    @(posedge clk);
    #1;
    checks++;
    if (fwd_a !== 4'b0101) begin
      errors++;
      $display("FAIL b2b_r0 got %b exp 0101", fwd_a);
    end
    drain(2);
  endtask

  task automatic test_mispredict();
    int na, nb;
    for (int s = 0; s < 2; s++) begin
      na = 0; nb = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        ex_mispredict = (i == 0) || (s == 1 && i == 2);
        #1;
        if (fl_a) na++;
        if (fl_b) nb++;
        if (i == 0) begin
          checks++;
          if (fl_a !== 1'b1) begin
            errors++;
            $display("FAIL misp_same_cycle got %b exp 1", fl_a);
          end
        end
      end
      checks++;
      if (na != 3) begin
        errors++;
        $display("FAIL misp_len_d4 s%0d got %0d exp 3", s, na);
      end
      checks++;
      if (nb != (s == 1 ? 2 : 1)) begin
        errors++;
        $display("FAIL misp_len_d2 s%0d got %0d exp %0d", s, nb, (s == 1 ? 2 : 1));
      end
    end
    @(negedge clk);  // load-use and mispredict together: flush wins
    id_valid = 1; id_src = {3'd1, 3'd4}; id_src_used = 2'b11;
    ex_wen = 1; ex_is_load = 1; ex_rd = 3'd4; ex_mispredict = 1;
    #1;
    checks++;
    if ({sf_a, bi_a, fl_a} !== 3'b001) begin
      errors++;
      $display("FAIL misp_vs_lu got %b exp 001", {sf_a, bi_a, fl_a});
    end
    drain(5);
  endtask

  task automatic test_memwait();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dmem_busy = 1; ex_mispredict = 1;
      #1;
      checks++;
      if ({sa_a, bw_a, fl_a} !== 3'b110) begin
        errors++;
        $display("FAIL memwait_c%0d got %b exp 110", i, {sa_a, bw_a, fl_a});
      end
    end
    @(negedge clk);
    dmem_busy = 0;
    #1;
    checks++;
    if ({sa_a, bw_a, fl_a} !== 3'b001) begin
      errors++;
      $display("FAIL memwait_exit got %b exp 001", {sa_a, bw_a, fl_a});
    end
    drain(5);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    ex_mispredict = 1;
    @(negedge clk);
    ex_mispredict = 0;  // dut_a now in SQUASH with counter 2
    #1;
    checks++;
    if (fl_a !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre got %b exp 1", fl_a);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({sf_a, bi_a, fl_a, sa_a, bw_a, byp_a, fwd_a} !== '0) begin
      errors++;
      $display("FAIL arst_now got %b exp 0", {sf_a, bi_a, fl_a, sa_a, bw_a, byp_a, fwd_a});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({sf_a, bi_a, fl_a, sa_a, bw_a, fwd_a} !== '0) begin
        errors++;
        $display("FAIL arst_idle_c%0d got %b exp 0", i, {sf_a, bi_a, fl_a, sa_a, bw_a, fwd_a});
      end
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      dmem_busy = 1;
    end
    @(negedge clk);
    dmem_busy = 0;
    checks++;
    if (pmw_a !== 4'd15) begin
      errors++;
      $display("FAIL perf_sat got %0d exp 15", pmw_a);
    end
    perf_clr = 1;
    @(negedge clk);
    perf_clr = 0;
    checks++;
    if ({plu_a, psq_a, pmw_a} !== '0) begin
      errors++;
      $display("FAIL perf_clr got %h exp 0", {plu_a, psq_a, pmw_a});
    end
  endtask
`endif

  // Reference: rem = flush cycles still owed after a mispredict cycle.
  task automatic test_random();
    int rem, busy_left;
    logic [2*NS-1:0] m_fwd, f_next;
    logic lu, e_sf, e_bi, e_fl, e_sa, e_bw;
    logic [NS-1:0] e_byp;
    logic [RB-1:0] sk;
    rst = 1'b0;
    set_idle();
    @(negedge clk);
    rst = 1'b1;
    rem = 0; busy_left = 0; m_fwd = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks++;
      if (fwd_a !== m_fwd) begin
        errors++;
        $display("FAIL rnd_fwd cyc %0d got %b exp %b", c, fwd_a, m_fwd);
      end
      id_valid    = ($urandom_range(0, 3) != 0);
      id_src      = {RB'($urandom_range(0, 3)), RB'($urandom_range(0, 3))};
      id_src_used = NS'($urandom_range(0, 3));
      ex_wen      = $urandom_range(0, 1) == 1;
      ex_is_load  = $urandom_range(0, 2) == 0;
      ex_rd       = RB'($urandom_range(0, 3));
      mem_wen     = $urandom_range(0, 1) == 1;
      mem_rd      = RB'($urandom_range(0, 3));
      wb_wen      = $urandom_range(0, 1) == 1;
      wb_rd       = RB'($urandom_range(0, 3));
      ex_mispredict = $urandom_range(0, 9) == 0;
      if (busy_left == 0 && $urandom_range(0, 11) == 0) busy_left = $urandom_range(1, 4);
      dmem_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      #1;
      lu = 0; e_byp = '0; f_next = '0;
      for (int k = 0; k < NS; k++) begin
        sk = id_src[k*RB +: RB];
        if (id_valid && id_src_used[k]) begin
          if (ex_wen && ex_is_load && sk == ex_rd) lu = 1;
          if (wb_wen && sk == wb_rd) e_byp[k] = 1;
          if (ex_wen && !ex_is_load && sk == ex_rd) f_next[2*k +: 2] = 2'd1;
          else if (mem_wen && sk == mem_rd) f_next[2*k +: 2] = 2'd2;
        end
      end
      {e_sf, e_bi, e_fl, e_sa, e_bw} = '0;
      if (dmem_busy) begin
        e_sa = 1; e_bw = 1;
      end else if (rem > 0) begin
        e_fl = 1; rem--;
      end else if (ex_mispredict) begin
        e_fl = 1; rem = DA - 2;
      end else if (lu) begin
        e_sf = 1; e_bi = 1;
      end
      checks++;
      if ({sf_a, bi_a, fl_a, sa_a, bw_a, byp_a} !== {e_sf, e_bi, e_fl, e_sa, e_bw, e_byp}) begin
        errors++;
        $display("FAIL rnd_ctl cyc %0d got %b exp %b", c,
                 {sf_a, bi_a, fl_a, sa_a, bw_a, byp_a}, {e_sf, e_bi, e_fl, e_sa, e_bw, e_byp});
      end
      if (!dmem_busy) m_fwd = (e_fl || e_bi) ? '0 : f_next;
    end
    drain(6);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_back_to_back();
    test_mispredict();
    test_memwait();
    test_async_reset();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
